toy_mmio_responder: RTL and testbench

- Memory-mapped peripheral responder on the RISC_TOY data port (DREQ/DRW/DADDR/DWDATA/DRDATA); the slave end of the core's data-memory interface, alongside DATA_MEM.
- Provides a free-running cycle counter, a write-only console FIFO drained over a valid/ready stream, and a halt/exit-code register so benches end on a program-written result.
- Read timing matches the SRAM: data appears on DRDATA the cycle after the request.

---
 rtl/toy_mmio_pkg.sv | 24 ++
 rtl/toy_mmio_responder_if.sv | 28 ++
 rtl/toy_mmio_fifo.sv | 67 ++++++
 rtl/toy_mmio_responder.sv | 145 ++++++++++++++
 tb/tb_toy_mmio_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/toy_mmio_pkg.sv
// rtl/toy_mmio_pkg.sv - register map, STATUS bit positions and default window for toy_mmio_responder
package toy_mmio_pkg;

    localparam logic [17:0] BASE_HI_DEFAULT = 18'h3FFFF;

    localparam logic [11:0] OFF_CYCLE  = 12'h000;
    localparam logic [11:0] OFF_TOHOST = 12'h004;
    localparam logic [11:0] OFF_STATUS = 12'h008;
    localparam logic [11:0] OFF_HALT   = 12'h00C;
    localparam logic [11:0] OFF_CMP    = 12'h010;

    localparam int STS_EMPTY_BIT = 16;
    localparam int STS_FULL_BIT  = 17;
    localparam int STS_OVF_BIT   = 18;
    localparam int STS_HALT_BIT  = 19;

    typedef struct packed {
        logic        hit;
        logic        rd;
        logic        wr;
        logic [11:0] off;
    } mmio_acc_t;

endpackage

// File: rtl/toy_mmio_responder_if.sv
// rtl/toy_mmio_responder_if.sv - core data-port, console stream and halt signals of toy_mmio_responder
// TIMER_IRQ exists only when MMIO_TIMER_CMP_EN is defined.
interface toy_mmio_responder_if;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic        SEL;
    logic        TX_VALID;
    logic [7:0]  TX_DATA;
    logic        TX_READY;
    logic        HALT;
    logic [31:0] EXIT_CODE;
`ifdef MMIO_TIMER_CMP_EN
    logic        TIMER_IRQ;

    modport master (output DREQ, DRW, DADDR, DWDATA, TX_READY,
                    input  DRDATA, SEL, TX_VALID, TX_DATA, HALT, EXIT_CODE, TIMER_IRQ);
    modport slave  (input  DREQ, DRW, DADDR, DWDATA, TX_READY,
                    output DRDATA, SEL, TX_VALID, TX_DATA, HALT, EXIT_CODE, TIMER_IRQ);
`else
    modport master (output DREQ, DRW, DADDR, DWDATA, TX_READY,
                    input  DRDATA, SEL, TX_VALID, TX_DATA, HALT, EXIT_CODE);
    modport slave  (input  DREQ, DRW, DADDR, DWDATA, TX_READY,
                    output DRDATA, SEL, TX_VALID, TX_DATA, HALT, EXIT_CODE);
`endif
endinterface

// File: rtl/toy_mmio_fifo.sv
// rtl/toy_mmio_fifo.sv - synchronous show-ahead byte FIFO with push/pop/full/empty/count
module toy_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        pop,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
    assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/toy_mmio_responder.sv
// rtl/toy_mmio_responder.sv - MMIO responder: cycle counter, console FIFO, halt/exit-code register
// Optional compare timer (CMP register, TIMER_IRQ) built when MMIO_TIMER_CMP_EN is defined.
module toy_mmio_responder
    import toy_mmio_pkg::*;
#(
    parameter logic [17:0] BASE_HI    = BASE_HI_DEFAULT,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_AW    = 3
) (
    input logic                 CLK,
    input logic                 RSTN,
    toy_mmio_responder_if.slave bus
);
    mmio_acc_t          acc;
    logic               tohost_push, tx_pop;
    logic               fifo_full, fifo_empty;
    logic [7:0]         fifo_head;
    logic [FIFO_AW:0]   fifo_count;
    logic [31:0]        status;
    logic [31:0]        cycle_q, cycle_d, rdata_q, rdata_d, exit_q, exit_d;
    logic               sel_q, sel_d, ovf_q, ovf_d, halt_q, halt_d;
    logic               unused_addr_bits;
`ifdef MMIO_TIMER_CMP_EN
    logic [31:0]        cmp_q, cmp_d;
    logic               irq_q, irq_d;
`endif

    assign unused_addr_bits = ^bus.DADDR[1:0];

    always_comb begin
        acc.hit = bus.DREQ && (bus.DADDR[29:12] == BASE_HI);
        acc.rd  = acc.hit && !bus.DRW;
        acc.wr  = acc.hit && bus.DRW;
        acc.off = {bus.DADDR[11:2], 2'b00};
    end

    assign tohost_push = acc.wr && (acc.off == OFF_TOHOST);
    assign tx_pop      = !fifo_empty && bus.TX_READY;

    toy_mmio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (tohost_push),
        .din   (bus.DWDATA[7:0]),
        .pop   (tx_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // STATUS is built from registered state, so it shows occupancy before this cycle's push/pop.
    always_comb begin
        status                = '0;
        status[FIFO_AW:0]     = fifo_count;
        status[STS_EMPTY_BIT] = fifo_empty;
        status[STS_FULL_BIT]  = fifo_full;
        status[STS_OVF_BIT]   = ovf_q;
        status[STS_HALT_BIT]  = halt_q;
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        sel_d   = acc.rd;
        rdata_d = rdata_q;
        if (acc.rd) begin
            case (acc.off)
                OFF_CYCLE:  rdata_d = cycle_q;
                OFF_STATUS: rdata_d = status;
                OFF_HALT:   rdata_d = exit_q;
`ifdef MMIO_TIMER_CMP_EN
                OFF_CMP:    rdata_d = cmp_q;
`endif
                default:    rdata_d = 32'h0;
            endcase
        end

        ovf_d = ovf_q;
        if (acc.wr && (acc.off == OFF_STATUS)) begin
            ovf_d = 1'b0;
        end else if (tohost_push && fifo_full && !tx_pop) begin
            ovf_d = 1'b1;
        end

        halt_d = halt_q;
        exit_d = exit_q;
        if (acc.wr && (acc.off == OFF_HALT) && !halt_q) begin
            halt_d = 1'b1;
            exit_d = bus.DWDATA;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cycle_q <= '0;
            rdata_q <= '0;
            sel_q   <= 1'b0;
            ovf_q   <= 1'b0;
            halt_q  <= 1'b0;
            exit_q  <= '0;
        end else begin
            cycle_q <= cycle_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
            halt_q  <= halt_d;
            exit_q  <= exit_d;
        end
    end

`ifdef MMIO_TIMER_CMP_EN
    // A CMP write wins over a match in the same cycle; the new value compares from the next cycle.
    always_comb begin
        cmp_d = cmp_q;
        irq_d = irq_q || (cycle_q == cmp_q);
        if (acc.wr && (acc.off == OFF_CMP)) begin
            cmp_d = bus.DWDATA;
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cmp_q <= 32'hFFFF_FFFF;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign bus.TIMER_IRQ = irq_q;
`endif

    assign bus.DRDATA    = rdata_q;
    assign bus.SEL       = sel_q;
    assign bus.TX_VALID  = !fifo_empty;
    assign bus.TX_DATA   = fifo_head;
    assign bus.HALT      = halt_q;
    assign bus.EXIT_CODE = exit_q;

endmodule

// File: tb/tb_toy_mmio_responder.sv
// tb/tb_toy_mmio_responder.sv - self-checking bench for toy_mmio_responder with a queue-based reference model
`timescale 1ns/1ps
module tb_toy_mmio_responder;
    import toy_mmio_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [17:0] BASE  = 18'h3FFFF;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    toy_mmio_responder_if bus();

    toy_mmio_responder #(
        .BASE_HI    (BASE),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (3)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: register state as plain variables, console FIFO as a queue.
    int unsigned m_cycle, m_exit, m_rdata, m_cmp;
    bit          m_sel, m_ovf, m_halt, m_irq;
    logic [7:0]  m_q[$];

    function automatic int unsigned m_status();
        int unsigned s;
        s = m_q.size();
        if (m_q.size() == 0)     s |= 32'h0001_0000;
        if (m_q.size() == DEPTH) s |= 32'h0002_0000;
        if (m_ovf)               s |= 32'h0004_0000;
        if (m_halt)              s |= 32'h0008_0000;
        return s;
    endfunction

    function automatic int unsigned m_read(input int unsigned a);
        case (a)
            0:  return m_cycle;
            8:  return m_status();
            12: return m_exit;
`ifdef MMIO_TIMER_CMP_EN
            16: return m_cmp;
`endif
            default: return 0;
        endcase
    endfunction

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_cycle = 0; m_exit = 0; m_rdata = 0; m_cmp = 32'hFFFF_FFFF;
            m_sel = 0; m_ovf = 0; m_halt = 0; m_irq = 0;
            m_q.delete();
        end else begin
            bit          hit, pop, was_full, nxt_irq;
            int unsigned a;
            hit      = bus.DREQ && (bus.DADDR[29:12] == BASE);
            a        = 32'({bus.DADDR[11:2], 2'b00});
            was_full = (m_q.size() == DEPTH);
            pop      = (m_q.size() != 0) && bus.TX_READY;
            m_sel    = hit && !bus.DRW;
            if (m_sel) m_rdata = m_read(a);
            if (pop) void'(m_q.pop_front());
            nxt_irq = m_irq || (m_cycle == m_cmp);
            if (hit && bus.DRW) begin
                case (a)
                    4:  if (!was_full || pop) m_q.push_back(bus.DWDATA[7:0]); else m_ovf = 1;
                    8:  m_ovf = 0;
                    12: if (!m_halt) begin m_halt = 1; m_exit = bus.DWDATA; end
                    16: begin m_cmp = bus.DWDATA; nxt_irq = 0; end
                    default: ;
                endcase
            end
            m_irq   = nxt_irq;
            m_cycle = m_cycle + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge CLK);
            chk("DRDATA",    bus.DRDATA, m_rdata);
            chk("SEL",       32'(bus.SEL), 32'(m_sel));
            chk("TX_VALID",  32'(bus.TX_VALID), 32'(m_q.size() != 0));
            chk("TX_DATA",   32'(bus.TX_DATA), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
            chk("HALT",      32'(bus.HALT), 32'(m_halt));
            chk("EXIT_CODE", bus.EXIT_CODE, m_exit);
`ifdef MMIO_TIMER_CMP_EN
            chk("TIMER_IRQ", 32'(bus.TIMER_IRQ), 32'(m_irq));
`endif
        end
    endtask

    function automatic logic [29:0] addr(input logic [11:0] off);
        return {BASE, off[11:2], 2'b00};
    endfunction

    task automatic access(input bit w, input logic [29:0] a, input logic [31:0] d);
        bus.DREQ = 1'b1; bus.DRW = w; bus.DADDR = a; bus.DWDATA = d;
        @(negedge CLK);
        bus.DREQ = 1'b0; bus.DRW = 1'b0;
    endtask

    task automatic rd(input logic [11:0] off, output logic [31:0] d);
        access(1'b0, addr(off), 32'h0);
        d = bus.DRDATA;
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        access(1'b1, addr(off), d);
    endtask

    task automatic drain_expect(input logic [7:0] first, input string name);
        for (int i = 0; i < DEPTH; i++) begin
            chk({name, "_valid"}, 32'(bus.TX_VALID), 32'h1);
            chk({name, "_byte"},  32'(bus.TX_DATA), 32'(first + 8'(i)));
            @(negedge CLK);
        end
        chk({name, "_empty"}, 32'(bus.TX_VALID), 32'h0);
    endtask

    logic [31:0] a0, a1, s;
    logic [11:0] roff;

    initial begin
        bus.DREQ = 0; bus.DRW = 0; bus.DADDR = '0; bus.DWDATA = '0; bus.TX_READY = 0;
        fork compare_loop(); join_none

        repeat (3) @(negedge CLK);
        chk("reset_drdata", bus.DRDATA, 32'h0);
        chk("reset_exit",   bus.EXIT_CODE, 32'h0);
        RSTN = 1'b1;

        // Cycle counter: two reads issued 10 cycles apart.
        rd(OFF_CYCLE, a0);
        repeat (9) @(negedge CLK);
        rd(OFF_CYCLE, a1);
        chk("cycle_delta", a1 - a0, 32'd10);

        // Overflow with the consumer stalled, then stream out.
        bus.TX_READY = 0;
        for (int i = 0; i < 9; i++) wr(OFF_TOHOST, 32'h41 + i);
        rd(OFF_STATUS, s);
        chk("status_ovf", s, 32'h0006_0008);
        bus.TX_READY = 1;
        drain_expect(8'h41, "drain1");
        bus.TX_READY = 0;
        wr(OFF_STATUS, 32'h0);
        rd(OFF_STATUS, s);
        chk("status_ovf_clear", s, 32'h0001_0000);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) wr(OFF_TOHOST, 32'h10 + i);
        bus.TX_READY = 1;
        wr(OFF_TOHOST, 32'h18);
        bus.TX_READY = 0;
        rd(OFF_STATUS, s);
        chk("status_full_pushpop", s, 32'h0002_0008);
        bus.TX_READY = 1;
        drain_expect(8'h11, "drain2");
        bus.TX_READY = 0;

        // Halt register is write-once.
        wr(OFF_HALT, 32'h0000_002A);
        chk("halt_set",   32'(bus.HALT), 32'h1);
        chk("exit_code",  bus.EXIT_CODE, 32'h2A);
        wr(OFF_HALT, 32'h55);
        chk("exit_locked", bus.EXIT_CODE, 32'h2A);
        rd(OFF_HALT, s);
        chk("exit_read", s, 32'h2A);
        rd(OFF_STATUS, s);
        chk("status_halt", s, 32'h0009_0000);

        // Out-of-window accesses.
        access(1'b1, {BASE ^ 18'h00001, 10'h001, 2'b00}, 32'h99);
        chk("miss_sel_wr", 32'(bus.SEL), 32'h0);
        access(1'b0, {BASE ^ 18'h20000, 10'h002, 2'b00}, 32'h0);
        chk("miss_sel_rd", 32'(bus.SEL), 32'h0);
        chk("miss_drdata_held", bus.DRDATA, 32'h0009_0000);
        chk("miss_no_push", 32'(bus.TX_VALID), 32'h0);
        rd(OFF_STATUS, s);
        chk("hit_sel", 32'(bus.SEL), 32'h1);
        @(negedge CLK);
        chk("hit_sel_drop", 32'(bus.SEL), 32'h0);
        rd(12'h020, s);
        chk("unmapped_read", s, 32'h0);

`ifdef MMIO_TIMER_CMP_EN
        rd(OFF_CYCLE, a0);
        wr(OFF_CMP, a0 + 32'd21);
        chk("irq_low_start", 32'(bus.TIMER_IRQ), 32'h0);
        repeat (19) @(negedge CLK);
        chk("irq_low_before", 32'(bus.TIMER_IRQ), 32'h0);
        @(negedge CLK);
        chk("irq_rise", 32'(bus.TIMER_IRQ), 32'h1);
        repeat (3) @(negedge CLK);
        chk("irq_sticky", 32'(bus.TIMER_IRQ), 32'h1);
        wr(OFF_CMP, 32'hFFFF_FFFF);
        chk("irq_clear", 32'(bus.TIMER_IRQ), 32'h0);
        rd(OFF_CMP, s);
        chk("cmp_read", s, 32'hFFFF_FFFF);
`else
        rd(OFF_CMP, s);
        chk("cmp_absent", s, 32'h0);
`endif

        // Reset in the middle of activity.
        wr(OFF_TOHOST, 32'h77);
        wr(OFF_TOHOST, 32'h78);
        rd(OFF_CYCLE, s);
        #2 RSTN = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_drdata",   bus.DRDATA, 32'h0);
            chk("rst_sel",      32'(bus.SEL), 32'h0);
            chk("rst_txvalid",  32'(bus.TX_VALID), 32'h0);
            chk("rst_txdata",   32'(bus.TX_DATA), 32'h0);
            chk("rst_halt",     32'(bus.HALT), 32'h0);
            chk("rst_exit",     bus.EXIT_CODE, 32'h0);
        end
        RSTN = 1'b1;
        rd(OFF_CYCLE, s);
        chk("cycle_after_reset", s, 32'h0);

        // Randomised traffic checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            bus.TX_READY = 1'($urandom_range(0, 1));
            roff = 12'($urandom_range(0, 6) * 4);
            bus.DREQ   = ($urandom_range(0, 3) != 0);
            bus.DRW    = 1'($urandom_range(0, 1));
            bus.DADDR  = {(($urandom_range(0, 7) == 0) ? (BASE ^ 18'h00100) : BASE), roff[11:2], 2'(($urandom_range(0, 3)))};
            bus.DWDATA = $urandom;
            if (roff == OFF_CMP) bus.DWDATA = m_cycle + $urandom_range(0, 30);
            if (roff == OFF_HALT && $urandom_range(0, 15) != 0) bus.DRW = 1'b0;
            @(negedge CLK);
        end
        bus.DREQ = 0;
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
